// File: rtl/avl_mem_bridge_if.sv
// Avalon-MM bus between the memory bridge (master) and the external RAM (slave).
interface avl_mem_bridge_if #(
  parameter int RAM_ADDR_W = 26,
  parameter int RAM_DATA_W = 128
);
  logic                    avl_wait;
  logic                    avl_readdatavalid;
  logic [RAM_DATA_W-1:0]   avl_readdata;
  logic                    avl_read;
  logic                    avl_write;
  logic [RAM_ADDR_W-1:0]   avl_address;
  logic [RAM_DATA_W-1:0]   avl_writedata;
  logic [RAM_DATA_W/8-1:0] avl_byteenable;

  modport master (
    input  avl_wait,
    input  avl_readdatavalid,
    input  avl_readdata,
    output avl_read,
    output avl_write,
    output avl_address,
    output avl_writedata,
    output avl_byteenable
  );

  modport slave (
    output avl_wait,
    output avl_readdatavalid,
    output avl_readdata,
    input  avl_read,
    input  avl_write,
    input  avl_address,
    input  avl_writedata,
    input  avl_byteenable
  );
endinterface

// File: rtl/avl_mem_bridge.sv
// Bridges the CPU word-access port onto a wide Avalon-MM RAM port, one
// transaction at a time. Each CPU word maps onto a lane of the RAM word;
// reads that never see readdatavalid end with an error after TIMEOUT cycles.
module avl_mem_bridge #(
  parameter int RAM_ADDR_W = 26,
  parameter int RAM_DATA_W = 128,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  avl_mem_bridge_if.master    avl,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_MemRead,
  input  logic                mem_MemWrite,
  input  logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_data_out,
  output logic                mem_ready,
  output logic                mem_busy,
  output logic                mem_err
);

  localparam int BE_W     = DATA_W / 8;
  localparam int RAM_BE_W = RAM_DATA_W / 8;
  localparam int LANES    = RAM_DATA_W / DATA_W;
  localparam int BOFF     = $clog2(BE_W);
  localparam int LB       = $clog2(LANES);
  localparam int LB_W     = (LB > 0) ? LB : 1;
  localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept, capture, clear_data, err_d;

  logic [LB_W-1:0]       lane_d, lane_q;
  logic [RAM_ADDR_W-1:0] word_addr;
  logic [RAM_BE_W-1:0]   be_d;
  logic                  unused_addr_bits;

  logic                  avl_read_q, avl_write_q;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic [RAM_DATA_W-1:0] wdata_q;
  logic [RAM_BE_W-1:0]   be_q;

  // Request decode: lane within the RAM word, RAM word address, lane byte enables.
  assign lane_d    = (LB > 0) ? mem_addr[BOFF +: LB_W] : '0;
  assign word_addr = mem_addr[BOFF+LB +: RAM_ADDR_W];
  assign be_d      = mem_MemWrite ? (RAM_BE_W'(mem_be) << (lane_d * BE_W)) : '1;
  // Sub-word and above-window address bits are deliberately ignored.
  assign unused_addr_bits = ^mem_addr;

  assign avl.avl_read       = avl_read_q;
  assign avl.avl_write      = avl_write_q;
  assign avl.avl_address    = addr_q;
  assign avl.avl_writedata  = wdata_q;
  assign avl.avl_byteenable = be_q;

  // Next-state logic: request dispatch, Avalon handshake and read timeout.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    capture    = 1'b0;
    clear_data = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_MemRead && mem_MemWrite) begin
          accept  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (mem_MemWrite && mem_be == '0) begin
          accept  = 1'b1;
          state_d = DONE;
        end else if (mem_MemWrite) begin
          accept  = 1'b1;
          state_d = WR;
        end else if (mem_MemRead) begin
          accept  = 1'b1;
          state_d = RD;
        end
      end
      WR: begin
        if (!avl.avl_wait) state_d = DONE;
      end
      RD: begin
        if (!avl.avl_wait) begin
          if (avl.avl_readdatavalid) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = RWAIT;
          end
        end
      end
      RWAIT: begin
        if (avl.avl_readdatavalid) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          clear_data = 1'b1;
          err_d      = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and timeout counter.
  always_ff @(posedge iCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!iRST_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs, decoded from the next state, plus captured request fields.
  always_ff @(posedge iCLK) begin
    // NOTE: the datapath registers are reset too, because their reset values
    // are directly visible on the output ports.
    if (!iRST_n) begin
      avl_read_q   <= 1'b0;
      avl_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      lane_q       <= '0;
      mem_data_out <= '0;
      mem_ready    <= 1'b0;
      mem_busy     <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      avl_read_q  <= (state_d == RD);
      avl_write_q <= (state_d == WR);
      mem_ready   <= (state_d == DONE);
      mem_busy    <= (state_d != IDLE);
      mem_err     <= err_d;
      if (accept) begin
        addr_q  <= word_addr;
        wdata_q <= {LANES{mem_data_in}};
        be_q    <= be_d;
        lane_q  <= lane_d;
      end
      if (capture)
        mem_data_out <= avl.avl_readdata[lane_q*DATA_W +: DATA_W];
      else if (clear_data)
        mem_data_out <= '0;
    end
  end

endmodule

// File: tb/tb_avl_mem_bridge.sv
// Directed testbench for avl_mem_bridge with a lane/word-level expectation model.
module tb_avl_mem_bridge;

  localparam int RAM_ADDR_W = 26;
  localparam int RAM_DATA_W = 128;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int TIMEOUT    = 8;

  typedef enum int {K_NONE, K_WR, K_RD, K_NOP} kind_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_MemRead, mem_MemWrite;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_be;
  logic [31:0] mem_data_out;
  logic        mem_ready, mem_busy, mem_err;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cycles, rd_cycles, ready_cnt;
  bit mon_en = 1'b0;

  // Model expectations for the transaction in flight.
  kind_t        m_kind = K_NONE;
  logic [25:0]  m_addr;
  logic [15:0]  m_be;
  logic [127:0] m_wdata;
  logic [31:0]  m_rdata;
  logic         m_err;

  // DUT values recorded by the monitor for literal pinning.
  logic [25:0]  last_wr_addr, last_rd_addr;
  logic [15:0]  last_wr_be;
  logic [127:0] last_wr_data;
  logic [31:0]  last_rdata;
  logic         last_err;

  always #5 clk = ~clk;

  avl_mem_bridge_if #(.RAM_ADDR_W(RAM_ADDR_W), .RAM_DATA_W(RAM_DATA_W)) avl_bus ();

  avl_mem_bridge #(
    .RAM_ADDR_W(RAM_ADDR_W), .RAM_DATA_W(RAM_DATA_W),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .avl(avl_bus),
    .mem_addr(mem_addr), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_data_in(mem_data_in), .mem_be(mem_be), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .mem_busy(mem_busy), .mem_err(mem_err)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Expected Avalon view of a CPU request, from lane arithmetic on the byte address.
  task automatic model_set(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be,
                           input logic [127:0] rword, input logic tmo);
    int lane;
    lane    = int'((addr >> 2) % 4);
    m_addr  = 26'((addr >> 4) & 32'h03FF_FFFF);
    m_be    = 16'(16'(be) << (lane * 4));
    m_wdata = {data, data, data, data};
    m_rdata = tmo ? 32'h0 : 32'(rword >> (lane * 32));
    m_err   = 1'b0;
    if (rd && wr) begin
      m_kind = K_NOP;
      m_err  = 1'b1;
    end else if (wr && be == 4'h0) begin
      m_kind = K_NOP;
    end else if (wr) begin
      m_kind = K_WR;
    end else begin
      m_kind = K_RD;
      m_err  = tmo;
    end
  endtask

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (avl_bus.avl_write) wr_cycles++;
      if (avl_bus.avl_read)  rd_cycles++;
      if (mem_ready)         ready_cnt++;
      check("rw_exclusive", avl_bus.avl_read && avl_bus.avl_write, 1'b0);
      if (m_kind != K_WR) check("stray_write", avl_bus.avl_write, 1'b0);
      if (m_kind != K_RD) check("stray_read", avl_bus.avl_read, 1'b0);
      if (avl_bus.avl_write && m_kind == K_WR) begin
        check("wr_address", avl_bus.avl_address, m_addr);
        check("wr_byteenable", avl_bus.avl_byteenable, m_be);
        check("wr_writedata", avl_bus.avl_writedata, m_wdata);
        last_wr_addr = avl_bus.avl_address;
        last_wr_be   = avl_bus.avl_byteenable;
        last_wr_data = avl_bus.avl_writedata;
      end
      if (avl_bus.avl_read && m_kind == K_RD) begin
        check("rd_address", avl_bus.avl_address, m_addr);
        check("rd_byteenable", avl_bus.avl_byteenable, 16'hFFFF);
        last_rd_addr = avl_bus.avl_address;
      end
      if (m_kind == K_NONE) begin
        check("stray_ready", mem_ready, 1'b0);
      end else if (mem_ready) begin
        check("ready_err", mem_err, m_err);
        if (m_kind == K_RD) check("ready_data", mem_data_out, m_rdata);
        last_err   = mem_err;
        last_rdata = mem_data_out;
      end
    end
  end

  // One transaction: drive the request, play the slave script, measure latency.
  task automatic run_txn(input string name, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdat, input logic [3:0] be,
                         input int n_wait, input int valid_at, input logic [127:0] rword,
                         input logic tmo, input int exp_lat, input int exp_wr, input int exp_rd);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    model_set(rd, wr, addr, wdat, be, rword, tmo);
    @(posedge clk); #1;
    mem_addr = addr; mem_data_in = wdat; mem_be = be;
    mem_MemRead = rd; mem_MemWrite = wr;
    avl_bus.avl_wait = 1'b0; avl_bus.avl_readdatavalid = 1'b0;
    wr_cycles = 0; rd_cycles = 0; ready_cnt = 0;
    @(negedge clk); #1;
    check({name, "_busy_before"}, mem_busy, 1'b0);
    @(posedge clk);
    for (int c = 1; c <= 40 && !seen; c++) begin
      #1;
      avl_bus.avl_wait          = (c <= n_wait);
      avl_bus.avl_readdatavalid = (c == valid_at);
      avl_bus.avl_readdata      = (c == valid_at) ? rword : 128'hBAD0_BAD1_BAD2_BAD3_BAD4_BAD5_BAD6_BAD7;
      @(negedge clk); #1;
      check({name, "_busy"}, mem_busy, 1'b1);
      if (ready_cnt != 0) begin
        seen = 1'b1;
        lat  = c;
        mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
        m_kind = K_NONE;
      end
      @(posedge clk);
    end
    #1;
    avl_bus.avl_wait = 1'b0; avl_bus.avl_readdatavalid = 1'b0;
    mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
    m_kind = K_NONE;
    check({name, "_completed"}, seen, 1'b1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_write_cycles"}, wr_cycles, exp_wr);
    check({name, "_read_cycles"}, rd_cycles, exp_rd);
    @(negedge clk); #1;
    check({name, "_ready_after"}, mem_ready, 1'b0);
    check({name, "_busy_after"}, mem_busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_avl_read"}, avl_bus.avl_read, 1'b0);
    check({name, "_avl_write"}, avl_bus.avl_write, 1'b0);
    check({name, "_avl_address"}, avl_bus.avl_address, 26'h0);
    check({name, "_avl_writedata"}, avl_bus.avl_writedata, 128'h0);
    check({name, "_avl_byteenable"}, avl_bus.avl_byteenable, 16'h0);
    check({name, "_mem_data_out"}, mem_data_out, 32'h0);
    check({name, "_mem_ready"}, mem_ready, 1'b0);
    check({name, "_mem_busy"}, mem_busy, 1'b0);
    check({name, "_mem_err"}, mem_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    mem_addr = '0; mem_MemRead = 1'b0; mem_MemWrite = 1'b0; mem_data_in = '0; mem_be = '0;
    avl_bus.avl_wait = 1'b0; avl_bus.avl_readdatavalid = 1'b0; avl_bus.avl_readdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Writes: single cycle, backpressured, sub-word address bits set.
    run_txn("w1", 1'b0, 1'b1, 32'h14, 32'hA5A5_1234, 4'hF, 0, 0, '0, 1'b0, 2, 1, 0);
    check("w1_addr_lit", last_wr_addr, 26'h1);
    check("w1_be_lit", last_wr_be, 16'h00F0);
    check("w1_data_lit", last_wr_data, {32'hA5A5_1234, 32'hA5A5_1234, 32'hA5A5_1234, 32'hA5A5_1234});
    run_txn("wbp", 1'b0, 1'b1, 32'h3C, 32'h1122_3344, 4'h6, 3, 0, '0, 1'b0, 5, 4, 0);
    check("wbp_addr_lit", last_wr_addr, 26'h3);
    check("wbp_be_lit", last_wr_be, 16'h6000);
    run_txn("wlow", 1'b0, 1'b1, 32'h27, 32'hCAFE_F00D, 4'h8, 0, 0, '0, 1'b0, 2, 1, 0);
    check("wlow_be_lit", last_wr_be, 16'h0080);

    // Illegal requests complete without touching the bus.
    run_txn("both", 1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 0, 0, '0, 1'b0, 1, 0, 0);
    check("both_err_lit", last_err, 1'b1);
    run_txn("be0", 1'b0, 1'b1, 32'h10, 32'h5555_5555, 4'h0, 0, 0, '0, 1'b0, 1, 0, 0);
    check("be0_err_lit", last_err, 1'b0);

    // Read, valid five cycles after acceptance, lane 2.
    run_txn("r1", 1'b1, 1'b0, 32'h28, 32'h0, 4'h0, 0, 5,
            {32'h0000_DDDD, 32'h0000_CCCC, 32'h0000_BBBB, 32'h0000_AAAA}, 1'b0, 6, 0, 1);
    check("r1_data_lit", last_rdata, 32'h0000_CCCC);
    check("r1_err_lit", last_err, 1'b0);

    // Timeout, then a late beat that must be dropped.
    run_txn("tmo", 1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 0, 0, '0, 1'b1, 10, 0, 1);
    check("tmo_err_lit", last_err, 1'b1);
    check("tmo_data_lit", last_rdata, 32'h0);
    @(posedge clk); #1;
    ready_cnt = 0;
    avl_bus.avl_readdatavalid = 1'b1; avl_bus.avl_readdata = '1;
    @(posedge clk); #1;
    avl_bus.avl_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("late_beat_ready", ready_cnt, 0);
    check("late_beat_data", mem_data_out, 32'h0);

    // Zero-latency read, backpressured read with ignored upper address bits,
    // and valid arriving in the last cycle before the timeout fires.
    run_txn("r0", 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 0, 1,
            128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978, 1'b0, 2, 0, 1);
    check("r0_data_lit", last_rdata, 32'h1234_5678);
    run_txn("rw", 1'b1, 1'b0, 32'hC000_0030, 32'h0, 4'h0, 2, 4,
            {32'h0, 32'h0, 32'h0, 32'h5A5A_0001}, 1'b0, 5, 0, 3);
    check("rw_addr_lit", last_rd_addr, 26'h3);
    check("rw_data_lit", last_rdata, 32'h5A5A_0001);
    run_txn("redge", 1'b1, 1'b0, 32'h34, 32'h0, 4'h0, 0, 9,
            {32'h0, 32'h0, 32'hBEEF_0009, 32'h0}, 1'b0, 10, 0, 1);
    check("redge_data_lit", last_rdata, 32'hBEEF_0009);
    check("redge_err_lit", last_err, 1'b0);

    // Reset while the read sits in the wait-for-data state.
    model_set(1'b1, 1'b0, 32'h58, 32'h0, 4'h0, '0, 1'b1);
    @(posedge clk); #1;
    mem_addr = 32'h58; mem_MemRead = 1'b1;
    rd_cycles = 0; ready_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; mem_MemRead = 1'b0; m_kind = K_NONE;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_reset_outputs("midrst");
    check("midrst_read_seen", rd_cycles, 1);
    @(posedge clk); #1;
    avl_bus.avl_readdatavalid = 1'b1; avl_bus.avl_readdata = '1;
    @(posedge clk); #1;
    avl_bus.avl_readdatavalid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check("midrst_no_ready", ready_cnt, 0);
    check("midrst_idle", mem_busy, 1'b0);

    run_txn("rpost", 1'b1, 1'b0, 32'h28, 32'h0, 4'h0, 0, 1,
            {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0, 2, 0, 1);
    check("rpost_data_lit", last_rdata, 32'h3333_3333);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
